time_display_scan: RTL

//  Reads the 32-bit packed-BCD time word produced by the timer and drives a 6-digit multiplexed

---
 rtl/time_pkg.sv | 38 +++
 rtl/bcd_to_seg7.sv | 26 ++
 rtl/time_display_scan.sv | 113 +++++++++++
 3 files changed

// File: rtl/time_pkg.sv
// Shared constants and types for the packed-BCD time word and its display.
package time_pkg;

   localparam int NUM_DIGITS = 6;
   localparam int TIME_BITS  = 24;

   localparam int SEC_ONES_LSB = 0;
   localparam int SEC_TENS_LSB = 4;
   localparam int MIN_ONES_LSB = 8;
   localparam int MIN_TENS_LSB = 12;
   localparam int HR_ONES_LSB  = 16;
   localparam int HR_TENS_LSB  = 20;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [5:0] AN_OFF    = 6'h3F;

   typedef enum logic {IDLE, SCAN} scan_state_e;

   // Unreachable slot indices fall back to the first digit.
   function automatic logic [3:0] digit_nibble(
      input logic [TIME_BITS-1:0] w,
      input logic [2:0]           idx
   );
      logic [3:0] n;
      n = w[SEC_ONES_LSB +: 4];
      case (idx)
         3'd1:    n = w[SEC_TENS_LSB +: 4];
         3'd2:    n = w[MIN_ONES_LSB +: 4];
         3'd3:    n = w[MIN_TENS_LSB +: 4];
         3'd4:    n = w[HR_ONES_LSB +: 4];
         3'd5:    n = w[HR_TENS_LSB +: 4];
         default: n = w[SEC_ONES_LSB +: 4];
      endcase
      return n;
   endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD digit to active-low {g,f,e,d,c,b,a} segment pattern.
module bcd_to_seg7
   import time_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (bcd)
         4'd0:    seg = 7'b1000000;
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/time_display_scan.sv
// Multiplexed 6-digit scan of the timer's BCD word with per-frame snapshot.
module time_display_scan
   import time_pkg::*;
#(
   parameter int DIGIT_CYCLES = 50000,
   parameter int BLANK_CYCLES = 500,
   parameter bit LZ_BLANK     = 1'b1
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [31:0] time_data,
   output logic [5:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame
);

   localparam int PW = $clog2(DIGIT_CYCLES);
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIGIT_CYCLES - 1);
   localparam logic [PW-1:0] PRESC_LIT  = PW'(BLANK_CYCLES);
   localparam logic [2:0]    LAST_IDX   = 3'(NUM_DIGITS - 1);

   scan_state_e          state_q, state_d;
   logic [2:0]           idx_q, idx_d;
   logic [PW-1:0]        presc_q, presc_d;
   logic [TIME_BITS-1:0] snap_q, snap_d;
   logic [5:0]           an_d;
   logic [6:0]           seg_d, glyph;
   logic                 dp_d, frame_d;
   logic [3:0]           nibble;
   logic                 wrap, last, lz, lit;
   logic                 time_unused;

   assign time_unused = ^time_data[31:TIME_BITS];

   assign nibble = digit_nibble(snap_q, idx_q);
   assign wrap   = (presc_q == PRESC_LAST);
   assign last   = (idx_q >= LAST_IDX);
   assign lz     = LZ_BLANK && (idx_q == LAST_IDX) && (nibble == 4'd0);
   assign lit    = (presc_q >= PRESC_LIT) && !lz;

   bcd_to_seg7 u_dec (
      .bcd (nibble),
      .seg (glyph)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      presc_d = presc_q;
      snap_d  = snap_q;
      frame_d = 1'b0;
      an_d    = AN_OFF;
      seg_d   = SEG_BLANK;
      dp_d    = 1'b1;
      unique case (state_q)
         IDLE: begin
            if (enable) begin
               state_d = SCAN;
               snap_d  = time_data[TIME_BITS-1:0];
               idx_d   = '0;
               presc_d = '0;
               frame_d = 1'b1;
            end
         end
         SCAN: begin
            seg_d = glyph;
            if (lit) begin
               an_d = ~(6'b1 << idx_q);
               dp_d = !((idx_q == 3'd2) || (idx_q == 3'd4));
            end
            if (!enable) begin
               state_d = IDLE;
            end else if (wrap) begin
               presc_d = '0;
               if (last) begin
                  idx_d   = '0;
                  snap_d  = time_data[TIME_BITS-1:0];
                  frame_d = 1'b1;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               presc_d = presc_q + PW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         presc_q <= '0;
         snap_q  <= '0;
         an      <= AN_OFF;
         seg     <= SEG_BLANK;
         dp      <= 1'b1;
         frame   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         presc_q <= presc_d;
         snap_q  <= snap_d;
         an      <= an_d;
         seg     <= seg_d;
         dp      <= dp_d;
         frame   <= frame_d;
      end
   end

endmodule
